// File: rtl/uart_rx_core_if.sv
// Byte-side handshake bundle of the UART receiver.
// master: receiver drives word, valid and flags; slave: consumer drives ready.
interface uart_rx_core_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] data;
    logic                 valid;
    logic                 ready;
    logic                 parity_err;
    logic                 frame_err;
    logic                 overrun;

    modport master (
        output data, valid, parity_err, frame_err, overrun,
        input  ready
    );

    modport slave (
        input  data, valid, parity_err, frame_err, overrun,
        output ready
    );
endinterface

// File: rtl/uart_rx_core.sv
// Oversampled UART receiver: start check, LSB-first data, optional parity,
// 1/2 stop bits, held valid/ready word with parity/frame/overrun flags.
// Ports: clk, rst (sync, high), baud_tick, rx (async, idle high),
//   busy (FSM not idle), rx_if (master: data/valid/ready/flags).
// Option: define UART_RX_MAJORITY_EN for 2-of-3 majority bit decisions.
module uart_rx_core #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           baud_tick,
    input  logic           rx,
    output logic           busy,
    uart_rx_core_if.master rx_if
);
    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

`ifdef UART_RX_MAJORITY_EN
    localparam int DEC = OVERSAMPLE / 2 + 1;
`else
    localparam int DEC = OVERSAMPLE / 2;
`endif

    localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(OVERSAMPLE - 1);
    localparam logic [CNT_W-1:0] DEC_TICK  = CNT_W'(DEC);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);
    localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [2:0]           state;
    logic [CNT_W-1:0]     cnt;
    logic [CNT_W-1:0]     next_cnt;
    logic [IDX_W-1:0]     idx;
    logic                 stop_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 perr;
    logic                 exp_par;
    logic                 rx_q1;
    logic                 rx_s;
    logic                 sample;
    logic                 at_dec;
    logic                 at_wrap;

    // Two-flop synchroniser; idle-high reset so no spurious start.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_q1 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            rx_q1 <= rx;
            rx_s  <= rx_q1;
        end
    end

    // next_cnt is the index of the tick being taken now; 0 marks a bit boundary.
    assign next_cnt = (cnt == LAST_TICK) ? '0 : cnt + 1'b1;
    assign at_dec   = baud_tick && (next_cnt == DEC_TICK);
    assign at_wrap  = baud_tick && (next_cnt == '0);
    assign busy     = (state != S_IDLE);
    assign exp_par  = (PARITY == 1) ? ~(^shreg) : ^shreg;

`ifdef UART_RX_MAJORITY_EN
    logic s_early;
    logic s_mid;

    always_ff @(posedge clk) begin
        if (rst) begin
            s_early <= 1'b1;
            s_mid   <= 1'b1;
        end else if (baud_tick) begin
            if (next_cnt == CNT_W'(OVERSAMPLE / 2 - 1))
                s_early <= rx_s;
            if (next_cnt == CNT_W'(OVERSAMPLE / 2))
                s_mid <= rx_s;
        end
    end

    // Third vote is the live sample at the decision tick.
    assign sample = (s_early & s_mid) | (s_early & rx_s) | (s_mid & rx_s);
`else
    assign sample = rx_s;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= S_IDLE;
            cnt              <= '0;
            idx              <= '0;
            stop_idx         <= 1'b0;
            shreg            <= '0;
            perr             <= 1'b0;
            rx_if.data       <= '0;
            rx_if.valid      <= 1'b0;
            rx_if.parity_err <= 1'b0;
            rx_if.frame_err  <= 1'b0;
            rx_if.overrun    <= 1'b0;
        end else begin
            rx_if.frame_err <= 1'b0;
            rx_if.overrun   <= 1'b0;

            // Completion below may re-assert valid in the same clk.
            if (rx_if.valid && rx_if.ready)
                rx_if.valid <= 1'b0;

            if (state != S_IDLE && baud_tick)
                cnt <= next_cnt;

            case (state)
                S_IDLE: begin
                    if (baud_tick && !rx_s) begin
                        state    <= S_START;
                        cnt      <= '0;
                        idx      <= '0;
                        stop_idx <= 1'b0;
                        perr     <= 1'b0;
                    end
                end
                S_START: begin
                    if (at_dec && sample)
                        state <= S_IDLE;
                    else if (at_wrap)
                        state <= S_DATA;
                end
                S_DATA: begin
                    if (at_dec)
                        shreg[idx] <= sample;
                    if (at_wrap) begin
                        if (idx == LAST_IDX)
                            state <= (PARITY != 0) ? S_PARITY : S_STOP;
                        else
                            idx <= idx + 1'b1;
                    end
                end
                S_PARITY: begin
                    if (at_dec)
                        perr <= sample ^ exp_par;
                    if (at_wrap)
                        state <= S_STOP;
                end
                S_STOP: begin
                    if (at_dec) begin
                        if (!sample) begin
                            rx_if.frame_err <= 1'b1;
                            state           <= S_IDLE;
                        end else if (stop_idx == LAST_STOP) begin
                            // Leave early so a back-to-back start is seen.
                            state <= S_IDLE;
                            if (!rx_if.valid || rx_if.ready) begin
                                rx_if.data       <= shreg;
                                rx_if.parity_err <= perr;
                                rx_if.valid      <= 1'b1;
                            end else begin
                                rx_if.overrun <= 1'b1;
                            end
                        end
                    end else if (at_wrap) begin
                        stop_idx <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx_core.sv
// Bench for uart_rx_core: 8N1 and 8E1 instances, table of frames,
// scoreboard of expected words, hand sequences for timing corners.
module tb_uart_rx_core;
    localparam int BIT = 64;

`ifdef UART_RX_MAJORITY_EN
    localparam logic GL = 1'b1;
`else
    localparam logic GL = 1'b0;
`endif

    typedef struct {
        logic [7:0] d;
        logic       pe;
    } exp_t;

    typedef struct {
        int         dut;
        logic [7:0] d;
        logic       par;
        logic       stop;
        logic       exp_pe;
        logic       exp_fe;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic baud_tick = 1'b0;
    logic rx0 = 1'b1;
    logic rx2 = 1'b1;
    logic busy0;
    logic busy2;

    int total = 0;
    int bad = 0;
    int ferr0 = 0;
    int ferr2 = 0;
    int ovr0 = 0;
    int ovr2 = 0;

    exp_t q0[$];
    exp_t q2[$];
    vec_t vt[10];

    uart_rx_core_if #(.DATA_BITS(8)) if0 ();
    uart_rx_core_if #(.DATA_BITS(8)) if2 ();

    uart_rx_core #(
        .DATA_BITS(8), .OVERSAMPLE(16), .PARITY(0), .STOP_BITS(1)
    ) u0 (
        .clk(clk), .rst(rst), .baud_tick(baud_tick),
        .rx(rx0), .busy(busy0), .rx_if(if0)
    );

    uart_rx_core #(
        .DATA_BITS(8), .OVERSAMPLE(16), .PARITY(2), .STOP_BITS(1)
    ) u2 (
        .clk(clk), .rst(rst), .baud_tick(baud_tick),
        .rx(rx2), .busy(busy2), .rx_if(if2)
    );

    always #5 clk = ~clk;

    initial begin
        int k;
        k = 0;
        forever begin
            @(negedge clk);
            baud_tick = (k == 3);
            k = (k + 1) % 4;
        end
    end

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, got, exp);
        end
    endtask

    // Scoreboard and pulse monitors, sampled just after the falling edge.
    always begin
        @(negedge clk);
        #1;
        if (!rst) begin
            if (if0.valid && if0.ready) begin
                if (q0.size() == 0) begin
                    check("u0_unexpected_word", {24'd0, if0.data}, 32'hFFFF);
                end else begin
                    exp_t e;
                    e = q0.pop_front();
                    check("u0_data", {24'd0, if0.data}, {24'd0, e.d});
                    check("u0_perr", {31'd0, if0.parity_err}, {31'd0, e.pe});
                end
            end
            if (if2.valid && if2.ready) begin
                if (q2.size() == 0) begin
                    check("u2_unexpected_word", {24'd0, if2.data}, 32'hFFFF);
                end else begin
                    exp_t e;
                    e = q2.pop_front();
                    check("u2_data", {24'd0, if2.data}, {24'd0, e.d});
                    check("u2_perr", {31'd0, if2.parity_err}, {31'd0, e.pe});
                end
            end
            if (if0.frame_err) ferr0++;
            if (if0.overrun) ovr0++;
            if (if2.frame_err) ferr2++;
            if (if2.overrun) ovr2++;
            if (if0.frame_err || if0.overrun)
                check("u0_flags_excl", {31'd0, if0.frame_err & if0.overrun}, 0);
            if (if2.frame_err || if2.overrun)
                check("u2_flags_excl", {31'd0, if2.frame_err & if2.overrun}, 0);
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input int which, input logic v);
        if (which == 0) rx0 = v;
        else rx2 = v;
    endtask

    task automatic send_frame(input int which, input logic [7:0] d,
                              input logic par_en, input logic par,
                              input logic stop, input logic glitch);
        drive(which, 1'b0);
        wait_clk(BIT);
        for (int i = 0; i < 8; i++) begin
            drive(which, d[i]);
            if (glitch && i == 0) begin
                wait_clk(BIT / 2);
                drive(which, ~d[0]);
                wait_clk(4);
                drive(which, d[0]);
                wait_clk(BIT / 2 - 4);
            end else begin
                wait_clk(BIT);
            end
        end
        if (par_en) begin
            drive(which, par);
            wait_clk(BIT);
        end
        drive(which, stop);
        wait_clk(BIT);
        drive(which, 1'b1);
    endtask

    initial begin
        int fe_before;
        int ov_before;

        vt[0] = '{0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
        vt[1] = '{0, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0};
        vt[2] = '{0, 8'h55, 1'b0, 1'b0, 1'b0, 1'b1};
        vt[3] = '{0, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0};
        vt[4] = '{0, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0};
        vt[5] = '{2, 8'h41, 1'b1, 1'b1, 1'b1, 1'b0};
        vt[6] = '{2, 8'h41, 1'b0, 1'b1, 1'b0, 1'b0};
        vt[7] = '{2, 8'h07, 1'b1, 1'b1, 1'b0, 1'b0};
        vt[8] = '{2, 8'h07, 1'b0, 1'b1, 1'b1, 1'b0};
        vt[9] = '{2, 8'h5A, 1'b1, 1'b0, 1'b0, 1'b1};

        if0.ready = 1'b0;
        if2.ready = 1'b0;
        rst = 1'b1;
        wait_clk(4);
        check("rst_data", {24'd0, if0.data}, 0);
        check("rst_valid", {31'd0, if0.valid}, 0);
        check("rst_flags", {29'd0, if0.parity_err, if0.frame_err, if0.overrun}, 0);
        check("rst_busy", {30'd0, busy0, busy2}, 0);
        rst = 1'b0;
        wait_clk(BIT);

        // Held word until ready, then released one clk later.
        q0.push_back('{8'h41, 1'b0});
        send_frame(0, 8'h41, 1'b0, 1'b0, 1'b1, 1'b0);
        wait_clk(50);
        check("t1_valid_held", {31'd0, if0.valid}, 1);
        check("t1_data_held", {24'd0, if0.data}, 32'h41);
        check("t1_no_flags", {29'd0, if0.parity_err, if0.frame_err, if0.overrun}, 0);
        if0.ready = 1'b1;
        wait_clk(1);
        check("t1_valid_drop", {31'd0, if0.valid}, 0);
        check("t1_q_empty", q0.size(), 0);
        if2.ready = 1'b1;
        wait_clk(BIT);

        // False start: 3 ticks low.
        fe_before = ferr0;
        rx0 = 1'b0;
        wait_clk(10);
        check("t2_busy_hi", {31'd0, busy0}, 1);
        wait_clk(2);
        rx0 = 1'b1;
        wait_clk(38);
        check("t2_busy_lo", {31'd0, busy0}, 0);
        wait_clk(2 * BIT);
        check("t2_no_valid", {31'd0, if0.valid}, 0);
        check("t2_no_ferr", ferr0 - fe_before, 0);

        for (int i = 0; i < 10; i++) begin
            fe_before = (vt[i].dut == 0) ? ferr0 : ferr2;
            if (!vt[i].exp_fe) begin
                if (vt[i].dut == 0) q0.push_back('{vt[i].d, vt[i].exp_pe});
                else q2.push_back('{vt[i].d, vt[i].exp_pe});
            end
            send_frame(vt[i].dut, vt[i].d, vt[i].dut == 2, vt[i].par,
                       vt[i].stop, 1'b0);
            wait_clk(2 * BIT);
            if (vt[i].dut == 0) begin
                check("tab_u0_ferr", ferr0 - fe_before, {31'd0, vt[i].exp_fe});
                check("tab_u0_q", q0.size(), 0);
                check("tab_u0_busy", {31'd0, busy0}, 0);
            end else begin
                check("tab_u2_ferr", ferr2 - fe_before, {31'd0, vt[i].exp_fe});
                check("tab_u2_q", q2.size(), 0);
                check("tab_u2_busy", {31'd0, busy2}, 0);
            end
        end

        // Back-to-back frames with no consumer: one overrun, first word kept.
        if0.ready = 1'b0;
        ov_before = ovr0;
        q0.push_back('{8'h11, 1'b0});
        send_frame(0, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0);
        send_frame(0, 8'h22, 1'b0, 1'b0, 1'b1, 1'b0);
        wait_clk(BIT);
        check("t5_overrun", ovr0 - ov_before, 1);
        check("t5_data_kept", {24'd0, if0.data}, 32'h11);
        check("t5_valid", {31'd0, if0.valid}, 1);
        if0.ready = 1'b1;
        wait_clk(2);
        check("t5_q_empty", q0.size(), 0);
        check("t5_valid_drop", {31'd0, if0.valid}, 0);
        wait_clk(BIT);

        // Reset mid-frame clears a pending word and the frame in flight.
        if0.ready = 1'b0;
        send_frame(0, 8'h99, 1'b0, 1'b0, 1'b1, 1'b0);
        wait_clk(BIT);
        check("t6_pending", {23'd0, if0.valid, if0.data}, 32'h199);
        rx0 = 1'b0;
        wait_clk(BIT);
        rx0 = 1'b1;
        wait_clk(3 * BIT);
        check("t6_busy_mid", {31'd0, busy0}, 1);
        rst = 1'b1;
        wait_clk(3);
        check("t6_rst_out",
              {20'd0, if0.data, if0.valid, if0.parity_err, if0.frame_err, busy0},
              0);
        rst = 1'b0;
        if0.ready = 1'b1;
        wait_clk(2 * BIT);
        q0.push_back('{8'hA5, 1'b0});
        send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1, GL);
        wait_clk(2 * BIT);
        check("t6_q_empty", q0.size(), 0);
        check("t6_valid_drop", {31'd0, if0.valid}, 0);

        check("end_q0", q0.size(), 0);
        check("end_q2", q2.size(), 0);
        check("end_ovr2", ovr2, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
